logit_collector: RTL and testbench

Initiator-side companion to the argmax classifier stage. It accepts the dense layer's DIM signed logits as a valid/ready stream and assembles them into a held vector. It pulses start to the argmax unit, holds the vector stable until the done pulse arrives, and presents the captured class index on a valid/ready result port for the UART/LED reporting logic.

---
 rtl/logit_collector_if.sv | 23 ++
 rtl/logit_collector.sv | 120 ++++++++++++
 tb/tb_logit_collector.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/logit_collector_if.sv
// Stream-side bundle for logit_collector: logit input stream plus result output port.
// slave is the collector's view, master is the producer/consumer side.
interface logit_collector_if #(
    parameter int DATA_WIDTH = 16
);
    logic                         in_valid;
    logic signed [DATA_WIDTH-1:0] in_data;
    logic                         in_ready;
    logic                         res_valid;
    logic                         res_ready;
    logic [3:0]                   res_idx;
    logic                         res_err;

    modport master (
        output in_valid, in_data, res_ready,
        input  in_ready, res_valid, res_idx, res_err
    );

    modport slave (
        input  in_valid, in_data, res_ready,
        output in_ready, res_valid, res_idx, res_err
    );
endinterface

// File: rtl/logit_collector.sv
// Collects DIM logits into a held vector, launches argmax and holds the class index until taken.
// Optional done-watchdog enabled by defining COLLECTOR_WATCHDOG_EN.
module logit_collector #(
    parameter int DATA_WIDTH = 16,
    parameter int DIM        = 10,
    parameter int TIMEOUT    = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    logit_collector_if.slave             bus,
    output logic signed [DATA_WIDTH-1:0] vec [0:DIM-1],
    output logic                         start,
    input  logic                         done,
    input  logic [3:0]                   idx,
    output logic                         busy
);
    typedef enum logic [1:0] {StCollect, StLaunch, StWait, StHold} state_e;

    state_e     state_q, state_d;
    logic [3:0] count_q;
    logic       res_valid_q;
    logic [3:0] res_idx_q;
    logic       transfer, last, accept, timeout;

    assign transfer = bus.in_valid && bus.in_ready;
    assign last     = (count_q == 4'(DIM - 1));
    assign accept   = res_valid_q && bus.res_ready;

`ifdef COLLECTOR_WATCHDOG_EN
    localparam int WdW = $clog2(TIMEOUT + 1);
    logic [WdW-1:0] wd_q;
    logic           res_err_q;

    // Fires on the TIMEOUT-th WAIT cycle; done in that same cycle takes priority.
    assign timeout = (state_q == StWait) && (wd_q == WdW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset || state_q == StLaunch) begin
            wd_q <= '0;
        end else if (state_q == StWait) begin
            wd_q <= wd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            res_err_q <= 1'b0;
        end else if (state_q == StWait) begin
            if (done) begin
                res_err_q <= 1'b0;
            end else if (timeout) begin
                res_err_q <= 1'b1;
            end
        end
    end

    assign bus.res_err = res_err_q;
`else
    assign timeout     = 1'b0;
    assign bus.res_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StCollect;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StCollect: if (transfer && last) state_d = StLaunch;
            StLaunch:  state_d = StWait;
            StWait:    if (done || timeout) state_d = StHold;
            StHold:    if (accept) state_d = StCollect;
            default:   state_d = StCollect;
        endcase
    end

    always_comb begin
        bus.in_ready = (state_q == StCollect) && !reset;
        busy         = (state_q != StCollect);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q     <= '0;
            start       <= 1'b0;
            res_valid_q <= 1'b0;
            res_idx_q   <= '0;
            for (int i = 0; i < DIM; i++) begin
                vec[i] <= '0;
            end
        end else begin
            // Registered so the pulse lines up exactly with the LAUNCH cycle.
            start <= (state_d == StLaunch);
            if (transfer) begin
                vec[count_q] <= bus.in_data;
                count_q      <= last ? 4'd0 : count_q + 4'd1;
            end
            if (state_q == StWait) begin
                if (done) begin
                    res_idx_q   <= idx;
                    res_valid_q <= 1'b1;
                end else if (timeout) begin
                    res_idx_q   <= 4'hF;
                    res_valid_q <= 1'b1;
                end
            end
            if (state_q == StHold && accept) begin
                res_valid_q <= 1'b0;
            end
        end
    end

    assign bus.res_valid = res_valid_q;
    assign bus.res_idx   = res_idx_q;
endmodule

// File: tb/tb_logit_collector.sv
// Directed bench for logit_collector with a behavioural argmax responder and a result scoreboard.
module tb_logit_collector;
    localparam int DW      = 16;
    localparam int DIM     = 10;
    localparam int TIMEOUT = 64;

    logic                 clk   = 1'b0;
    logic                 reset = 1'b1;
    logic                 start;
    logic                 done  = 1'b0;
    logic [3:0]           idx   = 4'd0;
    logic                 busy;
    logic signed [DW-1:0] vec [0:DIM-1];

    logit_collector_if #(.DATA_WIDTH(DW)) bus ();

    logit_collector #(
        .DATA_WIDTH(DW),
        .DIM       (DIM),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus),
        .vec  (vec),
        .start(start),
        .done (done),
        .idx  (idx),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int n_vec     = 0;
    int n_err     = 0;
    int n_start   = 0;
    bit argmax_en = 1'b1;
    logic [4:0] exp_q[$];  // {err, idx}

    int v_main[DIM] = '{3, -7, 12, 0, 5, 12, -1, 4, 9, 2};
    int v_a[DIM]    = '{-5, 100, 7, 100, -300, 99, 0, 1, 2, 3};
    int v_b[DIM]    = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 32767};
    int v_low[DIM];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] first_max(input int lg[DIM]);
        int best = 0;
        for (int i = 1; i < DIM; i++) begin
            if (lg[i] > lg[best]) best = i;
        end
        return 4'(best);
    endfunction

    // Feed one vector; returns just after the edge that took the last logit.
    task automatic stream(input int lg[DIM], input bit bubbly, input bit push);
        int  i     = 0;
        int  guard = 0;
        bit  ph    = 1'b0;
        if (push) exp_q.push_back({1'b0, first_max(lg)});
        while (i < DIM && guard < 200) begin
            @(posedge clk);
            #1;
            ph           = bubbly ? !ph : 1'b1;
            bus.in_valid = ph;
            bus.in_data  = 16'(lg[i]);
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) i++;
            guard++;
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        if (i < DIM) check("stream_timeout", i, DIM);
    endtask

    task automatic wait_drain(input int limit);
        int t = 0;
        while (exp_q.size() != 0 && t < limit) begin
            @(negedge clk);
            t++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    always @(negedge clk) if (start === 1'b1) n_start++;

    // Argmax stand-in: first maximum of the held vector, done DIM+1 cycles after start.
    always begin
        @(negedge clk);
        if (start === 1'b1 && argmax_en) begin
            int best = 0;
            for (int i = 1; i < DIM; i++) begin
                if (vec[i] > vec[best]) best = i;
            end
            repeat (DIM + 1) @(posedge clk);
            #1;
            idx  = 4'(best);
            done = 1'b1;
            @(posedge clk);
            #1 done = 1'b0;
        end
    end

    // Scoreboard: pop on every accepted result.
    always @(negedge clk) begin
        if (bus.res_valid === 1'b1 && bus.res_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("result_expected", exp_q.size(), 1);
            end else begin
                logic [4:0] e;
                e = exp_q.pop_front();
                check("res_idx", bus.res_idx, e[3:0]);
                check("res_err", bus.res_err, e[4]);
            end
        end
    end

    initial begin
        int t, s0, diffs, seen;
        for (int i = 0; i < DIM; i++) v_low[i] = -32768;
        v_low[9] = -32767;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.res_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("in_ready_in_reset", bus.in_ready, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_start", start, 0);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_res_idx", bus.res_idx, 0);
        check("rst_res_err", bus.res_err, 0);
        check("rst_in_ready", bus.in_ready, 1);
        diffs = 0;
        for (int i = 0; i < DIM; i++) if (vec[i] !== '0) diffs++;
        check("rst_vec_zero", diffs, 0);

        // Basic inference, first maximum wins, start and done timing
        s0 = n_start;
        stream(v_main, 1'b0, 1'b1);
        @(negedge clk);
        check("start_after_last", start, 1);
        check("busy_launch", busy, 1);
        t = 0;
        while (!bus.res_valid && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("result_latency", t, DIM + 2);
        check("start_pulses", n_start - s0, 1);
        check("res_idx_first_max", bus.res_idx, 2);
        check("res_err_normal", bus.res_err, 0);

        // Back-pressure on result port
        diffs = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.res_valid !== 1'b1 || bus.res_idx !== 4'd2 || bus.in_ready !== 1'b0) diffs++;
        end
        check("hold_stable", diffs, 0);
        @(posedge clk);
        #1 bus.res_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1 bus.res_ready = 1'b0;
        @(negedge clk);
        check("in_ready_after_accept", bus.in_ready, 1);
        check("res_valid_after_accept", bus.res_valid, 0);
        check("queue_after_first", exp_q.size(), 0);

        // Bubbly input, vec frozen through WAIT
        stream(v_low, 1'b1, 1'b1);
        diffs = 0;
        t     = 0;
        while (t < 40) begin
            @(negedge clk);
            if (bus.res_valid) break;
            for (int i = 0; i < DIM; i++) if (vec[i] !== 16'(v_low[i])) diffs++;
            t++;
        end
        check("vec_frozen", diffs, 0);
        check("bubbly_res_idx", bus.res_idx, 9);
        @(posedge clk);
        #1 bus.res_ready = 1'b1;
        wait_drain(20);

        // Reset during WAIT abandons the run; late done ignored
        stream(v_a, 1'b0, 1'b0);
        @(negedge clk);
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("wait_rst_busy", busy, 0);
        check("wait_rst_res_valid", bus.res_valid, 0);
        diffs = 0;
        for (int i = 0; i < DIM; i++) if (vec[i] !== '0) diffs++;
        check("wait_rst_vec_zero", diffs, 0);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.res_valid !== 1'b0 || busy !== 1'b0) seen++;
        end
        check("late_done_ignored", seen, 0);
        stream(v_a, 1'b0, 1'b1);
        wait_drain(40);

        // Back-to-back with res_ready tied high
        s0 = n_start;
        stream(v_a, 1'b0, 1'b1);
        stream(v_b, 1'b0, 1'b1);
        wait_drain(60);
        check("b2b_start_pulses", n_start - s0, 2);

        // No done from argmax
        argmax_en     = 1'b0;
        bus.res_ready = 1'b0;
        stream(v_b, 1'b0, 1'b0);
        @(negedge clk);
`ifdef COLLECTOR_WATCHDOG_EN
        exp_q.push_back(5'h1F);
        t = 0;
        while (!bus.res_valid && t < TIMEOUT + 20) begin
            @(negedge clk);
            t++;
        end
        check("wd_latency", t, TIMEOUT + 1);
        check("wd_res_idx", bus.res_idx, 4'hF);
        check("wd_res_err", bus.res_err, 1);
        @(posedge clk);
        #1 bus.res_ready = 1'b1;
        wait_drain(10);
`else
        seen = 0;
        repeat (TIMEOUT + 16) begin
            @(negedge clk);
            if (bus.res_valid !== 1'b0 || bus.res_err !== 1'b0) seen++;
        end
        check("no_wd_no_result", seen, 0);
        check("no_wd_busy", busy, 1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("no_wd_recover", bus.in_ready, 1);
`endif
        argmax_en = 1'b1;
        check("final_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
